usb_ep_buffer: RTL and testbench

Parametrised multi-endpoint packet buffer between the `usb` protocol core's transaction interface and application byte streams. It replaces the single-pair queue glue with NUM_EP bulk endpoints (numbers 1..NUM_EP), each with a separate OUT FIFO and IN FIFO. Each FIFO has commit/rollback pointers, per-direction data toggles and automatic ACK/NAK. EP0 and unmapped endpoints are left to `usb_setup`; this block ignores them.

---
 rtl/usb_ep_pkg.sv | 16 +
 rtl/usb_ep_fifo.sv | 56 +++++
 rtl/usb_ep_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_usb_ep_buffer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ep_pkg.sv
// Shared handshake codes and transaction states for the usb_ep_buffer endpoint block.
package usb_ep_pkg;

    localparam logic [1:0] HS_ACK   = 2'b00;
    localparam logic [1:0] HS_NONE  = 2'b01;
    localparam logic [1:0] HS_NAK   = 2'b10;
    localparam logic [1:0] HS_STALL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OUT_RX = 2'd1,
        ST_IN_TX  = 2'd2,
        ST_END    = 2'd3
    } ep_state_t;

endpackage

// File: rtl/usb_ep_fifo.sv
// Show-ahead byte FIFO with committed and tentative pointers; TENT_WR selects which side
// (write or read) is tentative and therefore subject to commit/rewind.
module usb_ep_fifo #(
    parameter int DEPTH   = 128,
    parameter bit TENT_WR = 1'b1,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic          commit,
    input  logic          rewind,
    output logic [7:0]    rd_data,
    output logic [PW-1:0] level,
    output logic [PW-1:0] used
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_com, wr_tent, rd_com, rd_tent;
    logic [PW-1:0] wr_nxt, rd_nxt;

    assign wr_nxt = wr_tent + PW'(wr_en);
    assign rd_nxt = rd_tent + PW'(rd_en);

    // The committed side of the non-tentative direction simply tracks its tentative twin.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_com  <= '0;
            wr_tent <= '0;
            rd_com  <= '0;
            rd_tent <= '0;
        end else if (TENT_WR) begin
            wr_tent <= rewind ? wr_com : wr_nxt;
            rd_tent <= rd_nxt;
            rd_com  <= rd_nxt;
            if (commit) wr_com <= wr_nxt;
        end else begin
            wr_tent <= wr_nxt;
            wr_com  <= wr_nxt;
            rd_tent <= rewind ? rd_com : rd_nxt;
            if (commit) rd_com <= rd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_tent[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_tent[AW-1:0]];
    assign level   = wr_com - rd_tent;
    assign used    = wr_tent - rd_com;

endmodule

// File: rtl/usb_ep_buffer.sv
// Multi-endpoint bulk packet buffer between the usb core transaction interface and app streams.
// Define USB_EP_HALT_EN to add the ep_halt input, which STALLs an endpoint in both directions.
module usb_ep_buffer
    import usb_ep_pkg::*;
#(
    parameter int NUM_EP  = 2,
    parameter int DEPTH   = 128,
    parameter int MAX_PKT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  usb_rst,
    input  logic [3:0]            usb_endpoint,
    input  logic                  usb_transaction_active,
    input  logic                  usb_direction_in,
    input  logic                  usb_setup,
    input  logic                  usb_success,
    input  logic                  usb_data_strobe,
    input  logic [7:0]            usb_data_out,
    output logic [7:0]            usb_data_in,
    output logic                  usb_data_in_valid,
    output logic                  usb_data_toggle,
    output logic [1:0]            usb_handshake,
`ifdef USB_EP_HALT_EN
    input  logic [NUM_EP-1:0]     ep_halt,
`endif
    output logic [8*NUM_EP-1:0]   out_data,
    output logic [NUM_EP-1:0]     out_valid,
    input  logic [NUM_EP-1:0]     out_ready,
    input  logic [8*NUM_EP-1:0]   in_data,
    input  logic [NUM_EP-1:0]     in_valid,
    output logic [NUM_EP-1:0]     in_ready
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(MAX_PKT + 1);
    localparam int EW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

    ep_state_t         state;
    logic              rst_all, ta_q, succ_q, dir_q, mapped;
    logic [EW-1:0]     ep_q, ep_idx;
    logic [1:0]        hs_q, hs_c;
    logic              tog_q, tog_c;
    logic [CW-1:0]     cnt, len_q, len_c;
    logic [NUM_EP-1:0] out_tog, in_tog, halt, halt_clr;
    logic [PW-1:0]     out_level [NUM_EP];
    logic [PW-1:0]     out_used  [NUM_EP];
    logic [PW-1:0]     in_level  [NUM_EP];
    logic [PW-1:0]     in_used   [NUM_EP];
    logic [7:0]        out_rdata [NUM_EP];
    logic [7:0]        in_rdata  [NUM_EP];
    logic [PW-1:0]     out_used_sel, in_level_sel;
    logic              xfer_ack, usb_wr, usb_rd, end_commit, end_rewind;

    assign rst_all = rst | usb_rst;
    assign mapped  = (usb_endpoint != 4'd0) && (usb_endpoint <= 4'(NUM_EP)) && !usb_setup;
    assign ep_idx  = EW'(usb_endpoint - 4'd1);

`ifdef USB_EP_HALT_EN
    logic [NUM_EP-1:0] halt_q;
    assign halt     = ep_halt;
    assign halt_clr = halt_q & ~ep_halt;
    always_ff @(posedge clk) begin
        if (rst_all) halt_q <= '0;
        else         halt_q <= ep_halt;
    end
`else
    assign halt     = '0;
    assign halt_clr = '0;
`endif

    always_comb begin
        out_used_sel = '0;
        in_level_sel = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (ep_idx == EW'(i)) begin
                out_used_sel = out_used[i];
                in_level_sel = in_level[i];
            end
        end
    end

    // Token decode while idle; these values are frozen into hs_q/tog_q/len_q at transaction start.
    always_comb begin
        hs_c  = HS_NONE;
        tog_c = 1'b0;
        len_c = (in_level_sel >= PW'(MAX_PKT)) ? CW'(MAX_PKT) : CW'(in_level_sel);
        if (mapped) begin
            tog_c = usb_direction_in ? in_tog[ep_idx] : out_tog[ep_idx];
            if (halt[ep_idx])          hs_c = HS_STALL;
            else if (usb_direction_in) hs_c = (in_level_sel != '0) ? HS_ACK : HS_NAK;
            else                       hs_c = (out_used_sel <= PW'(DEPTH - MAX_PKT)) ? HS_ACK : HS_NAK;
        end
    end

    assign xfer_ack   = (hs_q == HS_ACK);
    assign usb_wr     = (state == ST_OUT_RX) && xfer_ack && usb_data_strobe && (cnt < CW'(MAX_PKT));
    assign usb_rd     = (state == ST_IN_TX) && xfer_ack && usb_data_strobe && (cnt < len_q);
    assign end_commit = (state == ST_END) && xfer_ack && succ_q;
    assign end_rewind = (state == ST_END) && !end_commit;

    assign usb_data_in_valid = (state == ST_IN_TX) && xfer_ack && (cnt < len_q);
    assign usb_handshake     = (state == ST_IDLE) ? hs_c : hs_q;
    assign usb_data_toggle   = (state == ST_IDLE) ? tog_c : tog_q;

    always_comb begin
        usb_data_in = 8'h00;
        for (int i = 0; i < NUM_EP; i++) begin
            if (usb_data_in_valid && ep_q == EW'(i)) usb_data_in = in_rdata[i];
        end
    end

    always_ff @(posedge clk) begin
        ta_q <= usb_transaction_active;
        if (rst_all) begin
            state  <= ST_IDLE;
            hs_q   <= HS_NONE;
            tog_q  <= 1'b0;
            ep_q   <= '0;
            dir_q  <= 1'b0;
            succ_q <= 1'b0;
            cnt    <= '0;
            len_q  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (usb_transaction_active && !ta_q && mapped) begin
                        state <= usb_direction_in ? ST_IN_TX : ST_OUT_RX;
                        hs_q  <= hs_c;
                        tog_q <= tog_c;
                        ep_q  <= ep_idx;
                        dir_q <= usb_direction_in;
                        cnt   <= '0;
                        len_q <= len_c;
                    end
                end
                ST_OUT_RX, ST_IN_TX: begin
                    if (usb_wr || usb_rd) cnt <= cnt + CW'(1);
                    if (!usb_transaction_active) begin
                        state  <= ST_END;
                        succ_q <= usb_success;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_all) begin
            out_tog <= '0;
            in_tog  <= '0;
        end else begin
            for (int i = 0; i < NUM_EP; i++) begin
                if (end_commit && ep_q == EW'(i)) begin
                    if (dir_q) in_tog[i]  <= ~in_tog[i];
                    else       out_tog[i] <= ~out_tog[i];
                end
                if (halt_clr[i]) begin
                    in_tog[i]  <= 1'b0;
                    out_tog[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_EP; i++) begin : g_ep
        logic sel;
        assign sel = (ep_q == EW'(i));

        usb_ep_fifo #(.DEPTH(DEPTH), .TENT_WR(1'b1)) u_out (
            .clk     (clk),
            .rst     (rst_all),
            .wr_en   (usb_wr && sel),
            .wr_data (usb_data_out),
            .rd_en   (out_valid[i] && out_ready[i]),
            .commit  (end_commit && sel && !dir_q),
            .rewind  (end_rewind && sel && !dir_q),
            .rd_data (out_rdata[i]),
            .level   (out_level[i]),
            .used    (out_used[i])
        );

        usb_ep_fifo #(.DEPTH(DEPTH), .TENT_WR(1'b0)) u_in (
            .clk     (clk),
            .rst     (rst_all),
            .wr_en   (in_valid[i] && in_ready[i]),
            .wr_data (in_data[8*i +: 8]),
            .rd_en   (usb_rd && sel),
            .commit  (end_commit && sel && dir_q),
            .rewind  (end_rewind && sel && dir_q),
            .rd_data (in_rdata[i]),
            .level   (in_level[i]),
            .used    (in_used[i])
        );

        assign out_valid[i]       = (out_level[i] != '0);
        assign in_ready[i]        = (in_used[i] < PW'(DEPTH));
        assign out_data[8*i +: 8] = out_valid[i] ? out_rdata[i] : 8'h00;
    end

endmodule

// File: tb/tb_usb_ep_buffer.sv
// Self-checking bench for usb_ep_buffer against a queue-based endpoint model.
// Exercises the ep_halt STALL path when built with USB_EP_HALT_EN.
module tb_usb_ep_buffer;
    import usb_ep_pkg::*;

    localparam int NUM_EP  = 2;
    localparam int DEPTH   = 128;
    localparam int MAX_PKT = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, usb_rst, usb_transaction_active, usb_direction_in, usb_setup, usb_success;
    logic usb_data_strobe, usb_data_in_valid, usb_data_toggle;
    logic [3:0] usb_endpoint;
    logic [7:0] usb_data_out, usb_data_in;
    logic [1:0] usb_handshake;
    logic [8*NUM_EP-1:0] out_data, in_data;
    logic [NUM_EP-1:0] out_valid, out_ready, in_valid, in_ready;
`ifdef USB_EP_HALT_EN
    logic [NUM_EP-1:0] ep_halt;
`endif

    usb_ep_buffer #(.NUM_EP(NUM_EP), .DEPTH(DEPTH), .MAX_PKT(MAX_PKT)) dut (
        .clk(clk), .rst(rst), .usb_rst(usb_rst), .usb_endpoint(usb_endpoint),
        .usb_transaction_active(usb_transaction_active), .usb_direction_in(usb_direction_in),
        .usb_setup(usb_setup), .usb_success(usb_success), .usb_data_strobe(usb_data_strobe),
        .usb_data_out(usb_data_out), .usb_data_in(usb_data_in), .usb_data_in_valid(usb_data_in_valid),
        .usb_data_toggle(usb_data_toggle), .usb_handshake(usb_handshake),
`ifdef USB_EP_HALT_EN
        .ep_halt(ep_halt),
`endif
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
    );

    int tests = 0;
    int fails = 0;
    byte unsigned out_m [NUM_EP][$];
    byte unsigned in_m  [NUM_EP][$];
    bit out_tog_m [NUM_EP];
    bit in_tog_m  [NUM_EP];
    bit halt_m    [NUM_EP];
    logic [1:0] hs;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_app(input string tag);
        logic [NUM_EP-1:0] ov, ir;
        for (int i = 0; i < NUM_EP; i++) begin
            ov[i] = (out_m[i].size() != 0);
            ir[i] = (in_m[i].size() < DEPTH);
        end
        check({tag, "_out_valid"}, out_valid, ov);
        check({tag, "_in_ready"}, in_ready, ir);
    endtask

    task automatic idle_tog(input int ep, input bit dir, input bit exp);
        usb_endpoint = 4'(ep);
        usb_direction_in = dir;
        #1;
        check(dir ? "idle_in_tog" : "idle_out_tog", usb_data_toggle, exp);
    endtask

    task automatic end_txn(input bit succ);
        usb_success = succ;
        usb_transaction_active = 1'b0;
        @(negedge clk);
    endtask

    task automatic usb_out(input int ep, input int n, input bit succ, input bit seq, output logic [1:0] hs_o);
        byte unsigned pkt[$];
        int idx = ep - 1;
        logic [1:0] exp_hs;
        for (int k = 0; k < n; k++) pkt.push_back(seq ? 8'(k) : 8'($urandom));
        exp_hs = halt_m[idx] ? HS_STALL :
                 ((DEPTH - out_m[idx].size()) >= MAX_PKT) ? HS_ACK : HS_NAK;
        usb_endpoint = 4'(ep); usb_direction_in = 1'b0; usb_setup = 1'b0;
        usb_transaction_active = 1'b1;
        @(negedge clk);
        hs_o = usb_handshake;
        check("out_hs", usb_handshake, exp_hs);
        check("out_tog", usb_data_toggle, out_tog_m[idx]);
        for (int k = 0; k < n; k++) begin
            usb_data_out = pkt[k]; usb_data_strobe = 1'b1;
            @(negedge clk);
            usb_data_strobe = 1'b0;
            repeat (3) @(negedge clk);
        end
        end_txn(succ);
        check("out_valid_fall1", out_valid[idx], out_m[idx].size() != 0);
        @(negedge clk);
        usb_success = 1'b0;
        if (succ && exp_hs == HS_ACK) begin
            for (int k = 0; k < imin(n, MAX_PKT); k++) out_m[idx].push_back(pkt[k]);
            out_tog_m[idx] = ~out_tog_m[idx];
        end
        check("out_valid_fall2", out_valid[idx], out_m[idx].size() != 0);
    endtask

    task automatic usb_in(input int ep, input bit succ);
        int idx = ep - 1;
        int len = halt_m[idx] ? 0 : imin(MAX_PKT, in_m[idx].size());
        logic [1:0] exp_hs = halt_m[idx] ? HS_STALL : (len > 0) ? HS_ACK : HS_NAK;
        usb_endpoint = 4'(ep); usb_direction_in = 1'b1; usb_setup = 1'b0;
        usb_transaction_active = 1'b1;
        @(negedge clk);
        check("in_hs", usb_handshake, exp_hs);
        check("in_tog", usb_data_toggle, in_tog_m[idx]);
        check("in_valid_start", usb_data_in_valid, len > 0);
        for (int k = 0; k < len; k++) begin
            check("in_byte", usb_data_in, in_m[idx][k]);
            usb_data_strobe = 1'b1;
            @(negedge clk);
            usb_data_strobe = 1'b0;
            check("in_valid_after_strobe", usb_data_in_valid, (k + 1) < len);
            if (k + 1 < len) check("in_next_byte", usb_data_in, in_m[idx][k+1]);
            repeat (3) @(negedge clk);
        end
        end_txn(succ);
        @(negedge clk);
        usb_success = 1'b0;
        if (succ && len > 0) begin
            for (int k = 0; k < len; k++) void'(in_m[idx].pop_front());
            in_tog_m[idx] = ~in_tog_m[idx];
        end
        check("in_ready_after", in_ready[idx], in_m[idx].size() < DEPTH);
    endtask

    task automatic push_in(input int ep, input int n);
        int idx = ep - 1;
        for (int k = 0; k < n; k++) begin
            byte unsigned b = 8'($urandom);
            check("app_in_ready", in_ready[idx], in_m[idx].size() < DEPTH);
            in_data[8*idx +: 8] = b; in_valid[idx] = 1'b1;
            @(negedge clk);
            in_valid[idx] = 1'b0;
            in_m[idx].push_back(b);
        end
    endtask

    task automatic pop_out(input int ep, input int n);
        int idx = ep - 1;
        for (int k = 0; k < n; k++) begin
            check("app_out_valid", out_valid[idx], 1'b1);
            check("app_out_data", out_data[8*idx +: 8], out_m[idx][0]);
            out_ready[idx] = 1'b1;
            @(negedge clk);
            out_ready[idx] = 1'b0;
            void'(out_m[idx].pop_front());
        end
        check("app_out_valid_end", out_valid[idx], out_m[idx].size() != 0);
    endtask

    task automatic usb_unmapped(input int ep, input bit setup, input bit dir);
        usb_endpoint = 4'(ep); usb_setup = setup; usb_direction_in = dir;
        usb_transaction_active = 1'b1;
        @(negedge clk);
        check("unmapped_hs", usb_handshake, HS_NONE);
        check("unmapped_in_valid", usb_data_in_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            usb_data_out = 8'($urandom); usb_data_strobe = 1'b1;
            @(negedge clk);
            usb_data_strobe = 1'b0;
            repeat (3) @(negedge clk);
        end
        end_txn(1'b1);
        @(negedge clk);
        usb_success = 1'b0; usb_setup = 1'b0;
        check_app("unmapped");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; usb_rst = 1'b0; usb_endpoint = 4'd0; usb_transaction_active = 1'b0;
        usb_direction_in = 1'b0; usb_setup = 1'b0; usb_success = 1'b0; usb_data_strobe = 1'b0;
        usb_data_out = 8'h00; out_ready = '0; in_data = '0; in_valid = '0;
`ifdef USB_EP_HALT_EN
        ep_halt = '0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_data_in", usb_data_in, 8'h00);
        check("rst_data_in_valid", usb_data_in_valid, 1'b0);
        check("rst_toggle", usb_data_toggle, 1'b0);
        check("rst_handshake", usb_handshake, HS_NONE);
        check("rst_out_data", out_data, '0);
        check_app("rst");

        // OUT 0x00..0x3F to EP1, commit and drain.
        usb_out(1, 64, 1'b1, 1'b1, hs);
        pop_out(1, 64);
        idle_tog(1, 1'b0, 1'b1);

        // Failed OUT leaves nothing behind; resend delivers exactly one packet.
        usb_out(1, 64, 1'b0, 1'b0, hs);
        idle_tog(1, 1'b0, 1'b1);
        usb_out(1, 64, 1'b1, 1'b0, hs);
        pop_out(1, 64);

        // 100 bytes to EP2 IN: 64, then 36, then NAK.
        push_in(2, 100);
        usb_in(2, 1'b1);
        usb_in(2, 1'b1);
        usb_in(2, 1'b1);

        // Failed IN resends identical bytes with the same toggle.
        push_in(2, 70);
        usb_in(2, 1'b0);
        usb_in(2, 1'b1);
        usb_in(2, 1'b1);

        // Free-space decision: 128 free, then 70 free, then 10 free.
        usb_out(1, 58, 1'b1, 1'b0, hs);
        usb_out(1, 60, 1'b1, 1'b0, hs);
        check("ack_at_70_free", hs, HS_ACK);
        usb_out(1, 8, 1'b1, 1'b0, hs);
        check("nak_at_10_free", hs, HS_NAK);
        pop_out(1, 118);

        // Bytes past MAX_PKT are dropped.
        usb_out(2, 66, 1'b1, 1'b0, hs);
        pop_out(2, 64);

        // EP0, EP3, and SETUP tokens are ignored.
        push_in(2, 5);
        usb_unmapped(0, 1'b0, 1'b0);
        usb_unmapped(3, 1'b0, 1'b1);
        usb_unmapped(1, 1'b1, 1'b0);
        usb_unmapped(2, 1'b1, 1'b1);

        for (int it = 0; it < 40; it++) begin
            int ep = int'($urandom_range(1, NUM_EP));
            case ($urandom_range(0, 3))
                0: usb_out(ep, int'($urandom_range(1, 70)), 1'($urandom_range(0, 1)), 1'b0, hs);
                1: usb_in(ep, 1'($urandom_range(0, 1)));
                2: push_in(ep, imin(int'($urandom_range(0, 80)), DEPTH - in_m[ep-1].size()));
                default: pop_out(ep, int'($urandom_range(0, out_m[ep-1].size())));
            endcase
        end

        // Bus reset in the middle of an IN transaction.
        push_in(1, imin(20, DEPTH - in_m[0].size()));
        usb_out(2, 10, 1'b1, 1'b0, hs);
        usb_endpoint = 4'd1; usb_direction_in = 1'b1; usb_transaction_active = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            usb_data_strobe = 1'b1;
            @(negedge clk);
            usb_data_strobe = 1'b0;
            repeat (3) @(negedge clk);
        end
        usb_rst = 1'b1; usb_transaction_active = 1'b0;
        @(negedge clk);
        usb_rst = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            out_m[i].delete(); in_m[i].delete();
            out_tog_m[i] = 1'b0; in_tog_m[i] = 1'b0;
        end
        check("usbrst_in_ready", in_ready, {NUM_EP{1'b1}});
        check("usbrst_out_valid", out_valid, '0);
        check("usbrst_data_in", usb_data_in, 8'h00);
        for (int i = 1; i <= NUM_EP; i++) begin
            idle_tog(i, 1'b0, 1'b0);
            idle_tog(i, 1'b1, 1'b0);
        end
        usb_in(1, 1'b1);

`ifdef USB_EP_HALT_EN
        push_in(1, 8);
        usb_out(1, 8, 1'b1, 1'b0, hs);
        usb_in(1, 1'b1);
        ep_halt = 2'b01; halt_m[0] = 1'b1;
        @(negedge clk);
        usb_in(1, 1'b1);
        usb_out(1, 8, 1'b1, 1'b0, hs);
        check("halt_out_stall", hs, HS_STALL);
        ep_halt = '0; halt_m[0] = 1'b0;
        repeat (2) @(negedge clk);
        out_tog_m[0] = 1'b0; in_tog_m[0] = 1'b0;
        idle_tog(1, 1'b0, 1'b0);
        idle_tog(1, 1'b1, 1'b0);
        usb_out(1, 8, 1'b1, 1'b0, hs);
        pop_out(1, out_m[0].size());
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
